// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer: drains the UART RX FIFO, frames 4-byte packets
// (SYNC, CMD, ARG, CHK), applies valid commands to motor registers.
//
// Ports:
//   clk, reset_n             clock, async active-low reset
//   read / readdata / rdempty  FIFO read side (non show-ahead)
//   cmd_valid, cmd_code, cmd_arg  accepted-command pulse and payload
//   motor_en, motor_dir, motor_speed  motor setpoints
//   err_pulse, err_count     rejected packet / timeout pulse and count
module uart_cmd_sequencer #(
  parameter logic [7:0] SYNC_BYTE      = 8'hAA,
  parameter int         TIMEOUT_CYCLES = 2500000,
  parameter int         TO_W           = 22
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       read,
  input  logic [7:0] readdata,
  input  logic       rdempty,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic [7:0] cmd_arg,
  output logic       motor_en,
  output logic       motor_dir,
  output logic [7:0] motor_speed,
  output logic       err_pulse,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    HUNT,
    CMD,
    ARG,
    CHK
  } state_t;

  // Expiry is taken on the edge where the idle count would reach
  // TIMEOUT_CYCLES, so a byte arriving on that same edge still wins.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic            cap;
  logic [7:0]      cmd_q;
  logic [7:0]      arg_q;
  logic [TO_W-1:0] to_cnt;

  logic       op_start;
  logic       op_stop;
  logic       op_fwd;
  logic       op_rev;
  logic       op_speed;
  logic       op_known;
  logic       chk_ok;
  logic [7:0] err_next;

  always_comb begin
    op_start = (cmd_q == 8'h01);
    op_stop  = (cmd_q == 8'h02);
    op_fwd   = (cmd_q == 8'h03);
    op_rev   = (cmd_q == 8'h04);
    op_speed = (cmd_q == 8'h05);
    op_known = op_start | op_stop | op_fwd | op_rev | op_speed;
    chk_ok   = (readdata == (SYNC_BYTE ^ cmd_q ^ arg_q));
    err_next = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= HUNT;
      read        <= 1'b0;
      cap         <= 1'b0;
      cmd_q       <= '0;
      arg_q       <= '0;
      to_cnt      <= '0;
      cmd_valid   <= 1'b0;
      cmd_code    <= '0;
      cmd_arg     <= '0;
      motor_en    <= 1'b0;
      motor_dir   <= 1'b0;
      motor_speed <= '0;
      err_pulse   <= 1'b0;
      err_count   <= '0;
    end else begin
      // One read in flight at most; readdata is valid while cap is high.
      read      <= !rdempty && !read;
      cap       <= read;
      cmd_valid <= 1'b0;
      err_pulse <= 1'b0;
      if (cap) begin
        to_cnt <= '0;
        case (state)
          HUNT: begin
            if (readdata == SYNC_BYTE) state <= CMD;
          end
          CMD: begin
            cmd_q <= readdata;
            state <= ARG;
          end
          ARG: begin
            arg_q <= readdata;
            state <= CHK;
          end
          CHK: begin
            state <= HUNT;
            if (chk_ok && op_known) begin
              cmd_valid <= 1'b1;
              cmd_code  <= cmd_q;
              cmd_arg   <= arg_q;
              unique case (1'b1)
                op_start: motor_en    <= 1'b1;
                op_stop:  motor_en    <= 1'b0;
                op_fwd:   motor_dir   <= 1'b0;
                op_rev:   motor_dir   <= 1'b1;
                op_speed: motor_speed <= arg_q;
                default: ;
              endcase
            end else begin
              err_pulse <= 1'b1;
              err_count <= err_next;
            end
          end
        endcase
      end else if (state != HUNT) begin
        if (to_cnt == TO_LAST) begin
          state     <= HUNT;
          to_cnt    <= '0;
          err_pulse <= 1'b1;
          err_count <= err_next;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

endmodule
